fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
- REQ-002 SHALL have parameter RESET_PC, default 32'h01000000, meaning first fetch address after reset.
- REQ-003 SHALL have ports:
  - clock  input  1  — the only clock; all state updates on its rising edge.
  - reset  input  1  — asynchronous, active-high.
  - imem_req  output  1  — instruction memory read request.
  - imem_addr  output  32  — request address.
  - imem_data  input  32  — read data, valid exactly one cycle after the request.
  - redirect  input  1  — branch/jump taken; flush the queue and restart fetch.
  - redirect_pc  input  32  — new fetch address.
  - out_valid  output  1  — head entry is available to decode.
  - out_ready  input  1  — decode accepts the head entry.
  - out_inst  output  32  — head instruction.
  - out_pc  output  32  — address of the head instruction.
  - occupancy  output  $clog2(DEPTH)+1  — number of stored entries.

Function
- REQ-004 SHALL hold fetch PC register pc_q and drive imem_addr = pc_q.
- REQ-005 SHALL assert imem_req when (occupancy + inflight) < DEPTH and redirect is low.
  - inflight is 1 if a request was issued in the previous cycle and not killed.
  - Pops in the same cycle do not free credit.
- REQ-006 SHALL increment pc_q by 4 on every issued request, wrapping modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
- REQ-007 SHALL, in the cycle after an unkilled request, push {imem_data, request pc} into the tail entry.
- REQ-008 SHALL drive out_valid = (occupancy != 0) and not redirect.
- REQ-009 SHALL drive out_inst and out_pc from the head entry when out_valid is 1, and 32'h0 when it is 0.
- REQ-010 SHALL pop the head entry when out_valid and out_ready are both 1.
- REQ-011 SHALL leave occupancy unchanged on a simultaneous push and pop.
- REQ-012 SHALL never overflow: the credit rule guarantees a free slot for every push.
- REQ-013 SHALL never underflow: a pop without out_valid has no effect.
- REQ-014 SHALL, when redirect is high:
  - set occupancy to 0 and reset the head/tail pointers;
  - kill any inflight response, whose data arriving next cycle is discarded;
  - load pc_q <= {redirect_pc[31:2], 2'b00};
  - suppress imem_req and ignore out_ready in that cycle.
- REQ-015 SHALL issue the first post-redirect request in the cycle after redirect deasserts, at the redirect address.
- REQ-016 SHALL let redirect take priority over every simultaneous push, pop and request.
- REQ-017 SHALL, with a continuously ready consumer, sustain one instruction per cycle after the initial fill latency.
- REQ-018 SHALL preserve fetch order: entries leave in increasing address order between redirects.

Reset
- REQ-019 SHALL, while reset is high, force:
  - pc_q = RESET_PC, occupancy = 0, inflight = 0, pointers = 0;
  - imem_req = 0, out_valid = 0, out_inst = 0, out_pc = 0.
- REQ-020 SHALL issue the first request at RESET_PC in the first clock edge cycle after reset deasserts.
- REQ-021 SHALL discard any inflight response when reset asserts mid-operation.
- REQ-022 SHALL NOT reset the queue storage array.

Configuration
- REQ-023 SHALL support macro FETCH_QUEUE_BYPASS_EN.
  - Defined: when occupancy is 0 and an unkilled response arrives, drive out_valid = 1 with imem_data and its pc in the same cycle. If accepted, the entry is not written. Request-to-out_valid latency is 1 cycle.
  - Undefined: responses are always written first. Request-to-out_valid latency is 2 cycles.
- REQ-024 SHALL give identical ordering and redirect behaviour with or without the macro.

Verification
- REQ-025 Reset release, out_ready=1, imem returns addr^32'hA5A5A5A5:
  - imem_addr sequence is 01000000, 01000004, ...;
  - out_pc/out_inst match in order;
  - the first out_valid is 2 cycles after the first request (1 cycle with bypass).
- REQ-026 out_ready=0 for 10 cycles with DEPTH=4:
  - occupancy saturates at 4;
  - imem_req is low once occupancy+inflight=4;
  - after out_ready=1, entries 01000000..0100000C drain in order with no gaps.
- REQ-027 redirect=1, redirect_pc=32'h00002003 with 3 entries queued and one inflight:
  - next cycle occupancy=0 and the inflight data is not pushed;
  - the following request is at 32'h00002000.
- REQ-028 redirect_pc=32'hFFFFFFF8, free run:
  - imem_addr is FFFFFFF8, FFFFFFFC, 00000000, 00000004;
  - out_pc follows the same sequence.
- REQ-029 Reset asserted asynchronously mid-stream with 2 entries queued:
  - out_valid, imem_req and occupancy drop to 0 immediately;
  - after release, fetch restarts at 01000000.
- REQ-030 Random out_ready (50%) over 1000 cycles with random redirects:
  - no overflow or underflow;
  - out_pc is strictly +4 between consecutive pops except directly after a redirect.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch engine with a small in-order queue in front
// of decode. Issues one sequential read per cycle while credit remains,
// captures each response one cycle later, and flushes on redirect.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, a returning
// response is presented to decode in the same cycle it arrives.
`timescale 1ns/1ps

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h01000000
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Fetch and queue bookkeeping
    logic [31:0]   pc_reg;
    logic [31:0]   req_pc_reg;      // address of the request whose data returns this cycle
    logic          inflight_reg;
    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    // Queue storage; never reset, contents are qualified by count_reg
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic [CW:0]   credit_sum;
    logic [31:0]   redirect_target;
    logic          queue_nonempty;
    logic          bypass_hit;
    logic          fire;
    logic          push;
    logic          pop;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign queue_nonempty  = (count_reg != '0);

    // Credit counts stored entries plus the outstanding response; a pop in
    // the same cycle is deliberately not counted as freeing a slot.
    assign credit_sum = {1'b0, count_reg} + (CW+1)'(inflight_reg);
    assign imem_req   = !reset && !redirect && (credit_sum < (CW+1)'(DEPTH));
    assign imem_addr  = pc_reg;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = !queue_nonempty && inflight_reg;
`else
    assign bypass_hit = 1'b0;
`endif

    assign out_valid = !reset && !redirect && (queue_nonempty || bypass_hit);
    assign fire      = out_valid && out_ready;

    // A bypassed response that decode takes immediately never enters storage
    assign push = inflight_reg && !redirect && !(bypass_hit && out_ready);
    assign pop  = fire && !bypass_hit;

    assign occupancy = count_reg;

    // Head presentation: zero when nothing is offered
    always_comb begin
        out_inst = 32'h0;
        out_pc   = 32'h0;
        if (out_valid) begin
            if (bypass_hit) begin
                out_inst = imem_data;
                out_pc   = req_pc_reg;
            end else begin
                out_inst = inst_mem[head_reg];
                out_pc   = pc_mem[head_reg];
            end
        end
    end

    // Fetch PC, inflight tracking and queue pointers; redirect overrides all
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg       <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (redirect) begin
            pc_reg       <= redirect_target;
            inflight_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            inflight_reg <= imem_req;
            if (imem_req) begin
                pc_reg     <= pc_reg + 32'd4;
                req_pc_reg <= pc_reg;
            end
            if (push) begin
                tail_reg <= tail_reg + PW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Capture the returning instruction together with its fetch address
    always_ff @(posedge clock) begin
        if (push) begin
            inst_mem[tail_reg] <= imem_data;
            pc_mem[tail_reg]   <= req_pc_reg;
        end
    end

endmodule
